// File: rtl/mod_inverse_pkg.sv
// Shared types and sizing helpers for the mod_inverse extended-Euclid engine.
package mod_inverse_pkg;

  // Engine control states.
  typedef enum logic [2:0] {
    IDLE,
    DIV,
    UPDATE,
    FIX,
    DONE
  } state_e;

  localparam int DEFAULT_WIDTH = 16;

  // Euclid-step bound for a given operand width (Lame worst case plus the
  // initial swap step when e >= m).
  function automatic int maxSteps(input int width);
    return (3 * width) / 2 + 2;
  endfunction

  // Width of a counter that must hold values 0..maxStepsVal.
  function automatic int stepCntWidth(input int maxStepsVal);
    return $clog2(maxStepsVal + 1);
  endfunction

  // Signed Bezout coefficients need one extra bit over the operand width.
  function automatic int coefWidth(input int width);
    return width + 1;
  endfunction

  localparam int DEFAULT_STEP_CNT_W = stepCntWidth(maxSteps(DEFAULT_WIDTH));

endpackage

// File: rtl/mod_inverse_seq_divider.sv
// seq_divider: WIDTH-bit restoring divider producing one quotient bit per
// cycle. The first quotient bit is computed on the start cycle, so the full
// quotient is registered WIDTH edges after start. done_o marks the cycle whose
// closing edge writes the final bit; q_o/rem_o are valid from the next cycle.
// A zero divisor yields q = all ones and rem = dividend. WIDTH must be >= 2.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] srcRem, srcQuo, srcDiv;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // One restoring-division iteration, sourced from the inputs on start and
  // from the working registers while busy.
  always_comb begin
    srcRem  = start_i ? '0 : rem_q;
    srcQuo  = start_i ? dividend_i : quo_q;
    srcDiv  = start_i ? divisor_i : div_q;
    shifted = {srcRem, srcQuo[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, srcDiv};

    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_o = busy_q && (cnt_q == CNT_W'(WIDTH - 1));

    if (start_i || busy_q) begin
      div_d = srcDiv;
      if (!trial[WIDTH+1]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {srcQuo[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {srcQuo[WIDTH-2:0], 1'b0};
      end
      if (start_i) begin
        cnt_d  = CNT_W'(1);
        busy_d = 1'b1;
      end else if (done_o) begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Working registers of the divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign q_o    = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/mod_inverse.sv
// mod_inverse: iterative extended-Euclid engine computing gcd(m, e) and, when
// the gcd is 1, e^-1 mod m. Optional constant-time mode is enabled by defining
// MOD_INVERSE_CONST_TIME_EN: dummy Euclid steps on shadow registers pad every
// operation to exactly MAX_STEPS divisions.
module mod_inverse
  import mod_inverse_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_STEPS = maxSteps(WIDTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [WIDTH-1:0]                   m_i,
  input  logic [WIDTH-1:0]                   e_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [WIDTH-1:0]                   gcd_o,
  output logic [WIDTH-1:0]                   inv_o,
  output logic                               no_inv_o,
  output logic [$clog2(MAX_STEPS+1)-1:0]     steps_o
);

  localparam int CW = coefWidth(WIDTH);
  localparam int SW = stepCntWidth(MAX_STEPS);

  state_e state_q, state_d;

  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     r0_q, r0_d;
  logic [WIDTH-1:0]     r1_q, r1_d;
  logic signed [CW-1:0] t0_q, t0_d;
  logic signed [CW-1:0] t1_q, t1_d;
  logic                 degen_q, degen_d;
  logic [SW-1:0]        steps_q, steps_d;

  logic [WIDTH-1:0]     gcdOut_q, gcdOut_d;
  logic [WIDTH-1:0]     invOut_q, invOut_d;
  logic                 noInv_q, noInv_d;
  logic [SW-1:0]        stepsOut_q, stepsOut_d;

`ifdef MOD_INVERSE_CONST_TIME_EN
  logic                 realDone_q, realDone_d;
  logic [WIDTH-1:0]     sh0_q, sh0_d;
  logic [WIDTH-1:0]     sh1_q, sh1_d;
  logic signed [CW-1:0] shT0_q, shT0_d;
  logic signed [CW-1:0] shT1_q, shT1_d;
  logic [SW-1:0]        ctSteps_q, ctSteps_d;
`endif

  logic                 divStart, divBusy, divDone;
  logic [WIDTH-1:0]     divA, divB, divQ, divRem;
  logic signed [CW-1:0] coefA, coefB;
  logic [CW-1:0]        prodTrunc;
  logic signed [CW-1:0] newT;
  logic [WIDTH-1:0]     invVal;
  logic                 noInvVal;

`ifdef MOD_INVERSE_CONST_TIME_EN
  assign divA  = realDone_q ? sh0_q  : r0_q;
  assign divB  = realDone_q ? sh1_q  : r1_q;
  assign coefA = realDone_q ? shT0_q : t0_q;
  assign coefB = realDone_q ? shT1_q : t1_q;
`else
  assign divA  = r0_q;
  assign divB  = r1_q;
  assign coefA = t0_q;
  assign coefB = t1_q;
`endif

  // The divider is kicked once on the first DIV cycle of each step.
  assign divStart = (state_q == DIV) && !divBusy;

  seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (divStart),
    .dividend_i(divA),
    .divisor_i (divB),
    .busy_o    (divBusy),
    .done_o    (divDone),
    .q_o       (divQ),
    .rem_o     (divRem)
  );

  // Coefficient update t0 - q*t1; |t| <= m, so the low CW bits are exact.
  assign prodTrunc = {1'b0, divQ} * $unsigned(coefB);
  assign newT      = coefA - $signed(prodTrunc);

  // Fold a negative coefficient back into [0, m); modular W-bit add is exact.
  assign invVal   = t0_q[WIDTH-1:0] + (t0_q[CW-1] ? m_q : '0);
  assign noInvVal = degen_q || (r0_q != WIDTH'(1));

  // Next-state and datapath control for the Euclid sequence.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    r0_d       = r0_q;
    r1_d       = r1_q;
    t0_d       = t0_q;
    t1_d       = t1_q;
    degen_d    = degen_q;
    steps_d    = steps_q;
    gcdOut_d   = gcdOut_q;
    invOut_d   = invOut_q;
    noInv_d    = noInv_q;
    stepsOut_d = stepsOut_q;
`ifdef MOD_INVERSE_CONST_TIME_EN
    realDone_d = realDone_q;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    shT0_d     = shT0_q;
    shT1_d     = shT1_q;
    ctSteps_d  = ctSteps_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          m_d     = m_i;
          r0_d    = m_i;
          r1_d    = e_i;
          t0_d    = '0;
          t1_d    = CW'(1);
          steps_d = '0;
          degen_d = (m_i == '0) || (e_i == '0);
`ifdef MOD_INVERSE_CONST_TIME_EN
          realDone_d = (e_i == '0);
          sh0_d      = m_i;
          sh1_d      = WIDTH'(1);
          shT0_d     = '0;
          shT1_d     = CW'(1);
          ctSteps_d  = '0;
          state_d    = DIV;
`else
          state_d = (e_i == '0) ? FIX : DIV;
`endif
        end
      end

      DIV: begin
        if (divDone) begin
          state_d = UPDATE;
        end
      end

      UPDATE: begin
`ifdef MOD_INVERSE_CONST_TIME_EN
        ctSteps_d = ctSteps_q + SW'(1);
        if (!realDone_q) begin
          r0_d    = r1_q;
          r1_d    = divRem;
          t0_d    = t1_q;
          t1_d    = newT;
          steps_d = steps_q + SW'(1);
          if (divRem == '0) begin
            realDone_d = 1'b1;
            sh0_d      = r1_q;
            sh1_d      = WIDTH'(1);
            shT0_d     = t1_q;
            shT1_d     = newT;
          end
        end else begin
          sh0_d  = sh1_q;
          sh1_d  = (divRem == '0) ? WIDTH'(1) : divRem;
          shT0_d = shT1_q;
          shT1_d = newT;
        end
        state_d = (ctSteps_q == SW'(MAX_STEPS - 1)) ? FIX : DIV;
`else
        r0_d    = r1_q;
        r1_d    = divRem;
        t0_d    = t1_q;
        t1_d    = newT;
        steps_d = steps_q + SW'(1);
        state_d = (divRem == '0) ? FIX : DIV;
`endif
      end

      FIX: begin
        gcdOut_d   = r0_q;
        noInv_d    = noInvVal;
        invOut_d   = noInvVal ? '0 : invVal;
        stepsOut_d = steps_q;
        state_d    = DONE;
      end

      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      m_q        <= '0;
      r0_q       <= '0;
      r1_q       <= '0;
      t0_q       <= '0;
      t1_q       <= '0;
      degen_q    <= 1'b0;
      steps_q    <= '0;
      gcdOut_q   <= '0;
      invOut_q   <= '0;
      noInv_q    <= 1'b0;
      stepsOut_q <= '0;
`ifdef MOD_INVERSE_CONST_TIME_EN
      realDone_q <= 1'b0;
      sh0_q      <= '0;
      sh1_q      <= '0;
      shT0_q     <= '0;
      shT1_q     <= '0;
      ctSteps_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      r0_q       <= r0_d;
      r1_q       <= r1_d;
      t0_q       <= t0_d;
      t1_q       <= t1_d;
      degen_q    <= degen_d;
      steps_q    <= steps_d;
      gcdOut_q   <= gcdOut_d;
      invOut_q   <= invOut_d;
      noInv_q    <= noInv_d;
      stepsOut_q <= stepsOut_d;
`ifdef MOD_INVERSE_CONST_TIME_EN
      realDone_q <= realDone_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      shT0_q     <= shT0_d;
      shT1_q     <= shT1_d;
      ctSteps_q  <= ctSteps_d;
`endif
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign gcd_o       = gcdOut_q;
  assign inv_o       = invOut_q;
  assign no_inv_o    = noInv_q;
  assign steps_o     = stepsOut_q;

endmodule

// File: tb/tb_mod_inverse.sv
// Self-checking bench for mod_inverse: directed and random operand pairs,
// back-pressure, degenerate operands and mid-operation reset. Expected
// results come from a software extended-Euclid model via a scoreboard queue.
module tb_mod_inverse;
  import mod_inverse_pkg::*;

  localparam int W  = 16;
  localparam int MS = maxSteps(W);
  localparam int SW = DEFAULT_STEP_CNT_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  m = '0;
  logic [W-1:0]  e = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  gcd;
  logic [W-1:0]  inv;
  logic          no_inv;
  logic [SW-1:0] steps;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acceptCyc = 0;

  typedef struct {
    logic [W-1:0] gcd;
    logic [W-1:0] inv;
    logic         noInv;
    int           steps;
    int           lat;
  } exp_t;

  exp_t  expQ[$];
  string tagQ[$];

  mod_inverse #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .m_i        (m),
    .e_i        (e),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .gcd_o      (gcd),
    .inv_o      (inv),
    .no_inv_o   (no_inv),
    .steps_o    (steps)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Plain extended Euclid on integers.
  function automatic void refModel(input longint mv, input longint ev,
                                   output longint g, output longint iv,
                                   output bit ni, output int k);
    longint r0, r1, t0, t1, q, tmp;
    k = 0;
    if (ev == 0) begin
      g = mv; iv = 0; ni = 1'b1;
      return;
    end
    r0 = mv; r1 = ev; t0 = 0; t1 = 1;
    while (r1 != 0) begin
      q = r0 / r1;
      tmp = r0 - q * r1; r0 = r1; r1 = tmp;
      tmp = t0 - q * t1; t0 = t1; t1 = tmp;
      k++;
    end
    g  = r0;
    ni = (g != 1) || (mv == 0);
    iv = ni ? 0 : ((t0 < 0) ? t0 + mv : t0);
  endfunction

  task automatic applyStimulus(input string tag, input int unsigned mv, input int unsigned ev);
    exp_t x;
    longint g, iv;
    bit ni;
    int k, n;
    refModel(longint'(mv), longint'(ev), g, iv, ni, k);
    x.gcd   = W'(g);
    x.inv   = W'(iv);
    x.noInv = ni;
    x.steps = k;
`ifdef MOD_INVERSE_CONST_TIME_EN
    x.lat = MS * (W + 1) + 2;
`else
    x.lat = k * (W + 1) + 2;
`endif
    expQ.push_back(x);
    tagQ.push_back(tag);
    m = W'(mv);
    e = W'(ev);
    in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkVal({tag, " accept"}, 32'(in_ready), 32'd1);
    acceptCyc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic checkOutput(input int holdCycles);
    exp_t x;
    string tag;
    int n;
    x   = expQ.pop_front();
    tag = tagQ.pop_front();
    n = 0;
    while (!out_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkVal({tag, " out_valid timeout"}, 32'(out_valid), 32'd1);
    if (!out_valid) return;
    checkVal({tag, " latency"}, 32'(cyc - acceptCyc), 32'(x.lat));
    checkVal({tag, " gcd"},     32'(gcd),    32'(x.gcd));
    checkVal({tag, " inv"},     32'(inv),    32'(x.inv));
    checkVal({tag, " no_inv"},  32'(no_inv), 32'(x.noInv));
    checkVal({tag, " steps"},   32'(steps),  32'(x.steps));
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkVal({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      checkVal({tag, " hold in_ready"},  32'(in_ready),  32'd0);
      checkVal({tag, " hold gcd"},       32'(gcd),       32'(x.gcd));
      checkVal({tag, " hold inv"},       32'(inv),       32'(x.inv));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkVal({tag, " post out_valid"}, 32'(out_valid), 32'd0);
    checkVal({tag, " post in_ready"},  32'(in_ready),  32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, " in_ready"},  32'(in_ready),  32'd1);
    checkVal({tag, " out_valid"}, 32'(out_valid), 32'd0);
    checkVal({tag, " gcd"},       32'(gcd),       32'd0);
    checkVal({tag, " inv"},       32'(inv),       32'd0);
    checkVal({tag, " no_inv"},    32'(no_inv),    32'd0);
    checkVal({tag, " steps"},     32'(steps),     32'd0);
  endtask

  initial begin
    int unsigned rm, re;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("40/7", 40, 7);         checkOutput(0);
    applyStimulus("3120/17", 3120, 17);   checkOutput(0);
    applyStimulus("48/18", 48, 18);       checkOutput(0);
    applyStimulus("10/0", 10, 0);         checkOutput(0);
    applyStimulus("7/40", 7, 40);         checkOutput(0);
    applyStimulus("0/5", 0, 5);           checkOutput(0);
    applyStimulus("3120/1", 3120, 1);     checkOutput(0);

    out_ready = 1'b0;
    applyStimulus("hold 40/7", 40, 7);    checkOutput(20);

    applyStimulus("abort 40/7", 40, 7);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    checkResetState("mid reset");
    expQ.delete();
    tagQ.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus("11/3", 11, 3);         checkOutput(0);

    for (int i = 0; i < 4; i++) begin
      rm = $urandom_range(2, 65535);
      re = $urandom_range(1, 65535);
      applyStimulus($sformatf("rand %0d/%0d", rm, re), rm, re);
      checkOutput(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
